// File: rtl/encoder_pkg.sv
// Shared types and constants for the irq_priority_encoder block.
package encoder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_IDX_W = 3;

    localparam logic [1:0] ENA_ACTIVE = 2'b10;

    typedef enum logic [0:0] {
        StIdle,
        StPresent
    } state_e;

endpackage

// File: rtl/irq_priority_encoder_if.sv
// Request/handshake bundle for irq_priority_encoder; slave is the encoder side.
interface irq_priority_encoder_if
    import encoder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned IDX_W = DEFAULT_IDX_W
);

    logic [1:0]       iEna;
    logic [WIDTH-1:0] iReq;
    logic             iAck;
    logic             iClr;
    logic [IDX_W-1:0] oData;
    logic             oValid;
    logic [WIDTH-1:0] oPending;
    logic             oOverflow;

    modport master (
        output iEna, iReq, iAck, iClr,
        input  oData, oValid, oPending, oOverflow
    );

    modport slave (
        input  iEna, iReq, iAck, iClr,
        output oData, oValid, oPending, oOverflow
    );

endinterface

// File: rtl/msb_select.sv
// Combinational highest-set-bit selector: index of the top set bit plus an any-set flag.
module msb_select #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDX_W = 3
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    // Ascending scan so the highest set bit is the last one written.
    always_comb begin
        idx_o = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (vec_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

    assign any_o = |vec_i;

endmodule

// File: rtl/irq_priority_encoder.sv
// Sticky 8-to-3 priority encoder with valid/ack handshake.
// Define ENCODER_EDGE_DETECT_EN for rising-edge capture with a sticky overflow flag.
module irq_priority_encoder
    import encoder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned IDX_W = DEFAULT_IDX_W
) (
    input logic                   iClk,
    input logic                   iRst_n,
    irq_priority_encoder_if.slave bus
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic [IDX_W-1:0] data_q, data_d;
    logic [WIDTH-1:0] set;
    logic [WIDTH-1:0] ack_mask;
    logic [IDX_W-1:0] msb_idx;
    logic             msb_any;
    logic             active;
    logic             ack_fire;

    assign active   = (bus.iEna == ENA_ACTIVE);
    assign ack_fire = bus.iAck && (state_q == StPresent);
    assign ack_mask = ack_fire ? (WIDTH'(1) << data_q) : '0;

`ifdef ENCODER_EDGE_DETECT_EN
    logic [WIDTH-1:0] req_q, req_d;
    logic             overflow_q, overflow_d;

    assign req_d = bus.iReq;
    assign set   = active ? (bus.iReq & ~req_q) : '0;

    // A new edge on a bit still pending (and not leaving this cycle) is lost.
    always_comb begin
        overflow_d = overflow_q;
        if (bus.iClr) begin
            overflow_d = 1'b0;
        end else if (|(set & pending_q & ~ack_mask)) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            req_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            req_q      <= req_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.oOverflow = overflow_q;
`else
    assign set           = active ? bus.iReq : '0;
    assign bus.oOverflow = 1'b0;
`endif

    // Set is OR-ed after the ack clear so a re-asserted bit stays pending.
    always_comb begin
        if (bus.iClr) begin
            pending_d = '0;
        end else begin
            pending_d = (pending_q & ~ack_mask) | set;
        end
    end

    msb_select #(
        .WIDTH(WIDTH),
        .IDX_W(IDX_W)
    ) u_msb_select (
        .vec_i(pending_q),
        .idx_o(msb_idx),
        .any_o(msb_any)
    );

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q   <= StIdle;
            pending_q <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            data_q    <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (!bus.iClr && active && msb_any) begin
                    state_d = StPresent;
                end
            end
            StPresent: begin
                if (bus.iClr || ack_fire) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Priority is sampled only on the grant; oData otherwise keeps its last value.
    always_comb begin
        data_d = data_q;
        if (state_q == StIdle && state_d == StPresent) begin
            data_d = msb_idx;
        end
    end

    assign bus.oData    = data_q;
    assign bus.oValid   = (state_q == StPresent);
    assign bus.oPending = pending_q;

endmodule
